// File: rtl/data_write_buffer.sv
// Posted-write buffer on the CPU data port: stores are acked early and drained in order,
// loads pass through in order. Optional macro DWB_READ_BYPASS_EN lets non-matching loads overtake stores.
module data_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic        wbuf_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA} state_t;
    state_t state;

    logic [31:0]   fifo_addr  [DEPTH];
    logic [1:0]    fifo_size  [DEPTH];
    logic [31:0]   fifo_wdata [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic          full;
    logic          rd_busy;
    logic          wack_pending;
    logic          load_allowed;
    logic          st_hs;
    logic          ld_hs;
    logic          pop;
    logic          rd_done;

    assign full = (count == FULL_CNT);

`ifdef DWB_READ_BYPASS_EN
    logic          hazard;
    logic [PW-1:0] offs;

    // An entry is valid when its distance from head is below count; the draining head counts too.
    always_comb begin
        hazard = 1'b0;
        offs   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - head;
            if (({1'b0, offs} < count) && (fifo_addr[i][31:2] == cpu_addr[31:2]))
                hazard = 1'b1;
        end
    end
    assign load_allowed = !hazard;
`else
    assign load_allowed = (count == '0);
`endif

    assign st_hs = !rst && cpu_req && cpu_wr && !full && !rd_busy;
    assign ld_hs = !rst && cpu_req && !cpu_wr && (state == IDLE) && !wack_pending
                   && !rd_busy && load_allowed;
    assign pop     = (state == W_DATA) && mem_data_ok;
    assign rd_done = (state == R_DATA) && mem_data_ok;

    assign cpu_addr_ok = st_hs || ld_hs;
    assign cpu_data_ok = wack_pending || rd_done;
    assign cpu_rdata   = rd_done ? mem_rdata : '0;
    assign wbuf_empty  = (count == '0) && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rd_busy      <= 1'b0;
            wack_pending <= 1'b0;
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_size     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            wack_pending <= st_hs;
            if (st_hs) begin
                fifo_addr[tail]  <= cpu_addr;
                fifo_size[tail]  <= cpu_size;
                fifo_wdata[tail] <= cpu_wdata;
                tail             <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count <= count + (PW + 1)'(st_hs) - (PW + 1)'(pop);

            // mem_addr/mem_size double as the read register while a load is in flight
            case (state)
                IDLE: begin
                    if (ld_hs) begin
                        rd_busy   <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_addr  <= cpu_addr;
                        mem_size  <= cpu_size;
                        mem_wdata <= '0;
                        state     <= R_ADDR;
                    end else if (count != '0) begin
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= fifo_addr[head];
                        mem_size  <= fifo_size[head];
                        mem_wdata <= fifo_wdata[head];
                        state     <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (mem_data_ok)
                        state <= IDLE;
                end
                R_ADDR: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (mem_data_ok) begin
                        rd_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_write_buffer.sv
// Bench for data_write_buffer: transaction-level model (program-order memory image, pending store
// queue, memory slave) checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_data_write_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_addr_ok, cpu_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic        wbuf_empty;

    always #5 clk = ~clk;

    data_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_addr_ok(cpu_addr_ok),
        .cpu_data_ok(cpu_data_ok), .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .wbuf_empty(wbuf_empty)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    req_t        req_q[$];
    req_t        pend[$];
    logic [31:0] mem  [logic [29:0]];
    logic [31:0] arch [logic [29:0]];
    logic [31:0] mlog[$];

    bit          drop, ack_pend, load_out, ld_issued;
    logic [31:0] ld_exp, ld_addr;
    logic [1:0]  ld_size;
    bit          sl_busy, sl_wr, hold_aok;
    logic [31:0] sl_addr, sl_wdata;
    logic [1:0]  sl_size;
    int          sl_wait, aok_pct, dly_min, dly_max;
    bit          pv_wait, pv_wr;
    logic [1:0]  pv_size;
    logic [31:0] pv_addr, pv_wdata;
    int          st_acc, pops, pops_at_st_hs;
    int          last_st_hs_cyc, last_st_ack_cyc, last_ld_hs_cyc, last_ld_dok_cyc, last_pop_cyc;
    logic [31:0] last_ld_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata);
        req_t r;
        r.wr = wr; r.size = size; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] size,
                                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] m;
        case (size)
            2'd0:    m = 32'h0000_00FF << (8 * addr[1:0]);
            2'd1:    m = 32'h0000_FFFF << (16 * addr[1]);
            default: m = 32'hFFFF_FFFF;
        endcase
        return (old & ~m) | (wdata & m);
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_arch(input logic [31:0] a);
        return arch.exists(a[31:2]) ? arch[a[31:2]] : 32'h0;
    endfunction

    function automatic bit load_legal(input logic [31:0] a);
        bit ok;
        ok = !load_out && !ack_pend;
`ifdef DWB_READ_BYPASS_EN
        foreach (pend[i]) if (pend[i].addr[31:2] == a[31:2]) ok = 0;
`else
        if (pend.size() != 0) ok = 0;
`endif
        return ok;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.wr    = ($urandom_range(0, 9) < 6);
        r.size  = 2'($urandom_range(0, 2));
        r.addr  = 32'h1000 | (32'($urandom_range(0, 7)) << 2);
        if (r.size == 2'd0) r.addr[1:0] = 2'($urandom_range(0, 3));
        else if (r.size == 2'd1) r.addr[1] = 1'($urandom_range(0, 1));
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic bit quiet();
        return req_q.size() == 0 && !cpu_req && pend.size() == 0 && !load_out && !sl_busy;
    endfunction

    // One clock: drive at negedge, observe 1ns later, check against the model, advance the model.
    task automatic step();
        req_t r;
        bit   hs, rd_dok, same;
        @(negedge clk);
        cyc++;
        if (drop) begin cpu_req = 0; drop = 0; end
        if (!cpu_req && req_q.size() > 0) begin
            r = req_q.pop_front();
            cpu_req = 1; cpu_wr = r.wr; cpu_size = r.size; cpu_addr = r.addr; cpu_wdata = r.wdata;
        end
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = $urandom;
        if (sl_busy) begin
            if (sl_wait == 0) begin
                mem_data_ok = 1;
                if (!sl_wr) mem_rdata = rd_mem(sl_addr);
            end else sl_wait--;
        end else if (mem_req && !hold_aok)
            mem_addr_ok = ($urandom_range(1, 100) <= aok_pct);
        #1;
        hs     = cpu_req && cpu_addr_ok;
        rd_dok = sl_busy && mem_data_ok && !sl_wr;

        chk("wbuf_empty", wbuf_empty, pend.size() == 0 && !load_out);
        chk("cpu_data_ok", cpu_data_ok, ack_pend || rd_dok);
        chk("one_outstanding", mem_req && sl_busy, 0);
        if (rd_dok) begin
            chk("load_rdata", cpu_rdata, ld_exp);
            last_ld_data = cpu_rdata; last_ld_dok_cyc = cyc;
        end
        if (ack_pend && cpu_data_ok) last_st_ack_cyc = cyc;
        if (cpu_req && cpu_wr) chk("store_addr_ok", cpu_addr_ok, pend.size() < DEPTH && !load_out);
        if (cpu_req && !cpu_wr && cpu_addr_ok) chk("load_accept_legal", load_legal(cpu_addr), 1);
        if (pv_wait) begin
            same = mem_req && mem_wr == pv_wr && mem_size == pv_size && mem_addr == pv_addr
                   && (!pv_wr || mem_wdata == pv_wdata);
            chk("mem_stable", same, 1);
        end

        if (mem_req && mem_addr_ok) begin
            mlog.push_back(mem_addr);
            if (mem_wr) begin
                chk("write_has_store", pend.size() != 0, 1);
                if (pend.size() != 0) begin
                    chk("wr_addr", mem_addr, pend[0].addr);
                    chk("wr_size", mem_size, pend[0].size);
                    chk("wr_data", mem_wdata, pend[0].wdata);
                end
            end else begin
                chk("read_has_load", load_out && !ld_issued, 1);
                chk("rd_addr", mem_addr, ld_addr);
                chk("rd_size", mem_size, ld_size);
                ld_issued = 1;
            end
            sl_busy = 1; sl_wr = mem_wr; sl_addr = mem_addr; sl_size = mem_size;
            sl_wdata = mem_wdata;
            sl_wait = int'($urandom_range(dly_min, dly_max)) - 1;
        end else if (sl_busy && mem_data_ok) begin
            if (sl_wr) begin
                mem[sl_addr[31:2]] = merge(rd_mem(sl_addr), sl_size, sl_addr, sl_wdata);
                if (pend.size() != 0) void'(pend.pop_front());
                pops++; last_pop_cyc = cyc;
            end else begin
                load_out = 0; ld_issued = 0;
            end
            sl_busy = 0;
        end

        pv_wait = mem_req && !mem_addr_ok;
        pv_wr = mem_wr; pv_size = mem_size; pv_addr = mem_addr; pv_wdata = mem_wdata;
        ack_pend = hs && cpu_wr;
        if (hs) begin
            drop = 1;
            if (cpu_wr) begin
                pend.push_back(mk(1'b1, cpu_size, cpu_addr, cpu_wdata));
                arch[cpu_addr[31:2]] = merge(rd_arch(cpu_addr), cpu_size, cpu_addr, cpu_wdata);
                st_acc++; last_st_hs_cyc = cyc; pops_at_st_hs = pops;
            end else begin
                load_out = 1; ld_exp = rd_arch(cpu_addr); ld_addr = cpu_addr; ld_size = cpu_size;
                last_ld_hs_cyc = cyc;
            end
        end
    endtask

    task automatic run_quiet(input string name, input int budget);
        int n;
        n = 0;
        do begin step(); n++; end while (!quiet() && n < budget);
        chk(name, quiet(), 1);
    endtask

    initial begin
        int base, pbase, n;
        rst = 1; cpu_req = 0; cpu_wr = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
        hold_aok = 0; aok_pct = 100; dly_min = 1; dly_max = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_addr_ok", cpu_addr_ok, 0);  chk("rst_data_ok", cpu_data_ok, 0);
        chk("rst_rdata", cpu_rdata, 0);      chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wr", mem_wr, 0);        chk("rst_mem_size", mem_size, 0);
        chk("rst_mem_addr", mem_addr, 0);    chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_wbuf_empty", wbuf_empty, 1);
        rst = 0;

        // single store, addr_ok immediate, data_ok two cycles after the handshake
        dly_min = 2; dly_max = 2;
        req_q.push_back(mk(1'b1, 2'd2, 32'hBFAF_F000, 32'h1234_5678));
        step(); chk("t1_addr_ok", cpu_addr_ok, 1); chk("t1_req_t0", mem_req, 0);
        step(); chk("t1_ack", cpu_data_ok, 1);     chk("t1_req_t1", mem_req, 0);
        step(); chk("t1_req_t2", mem_req, 1);      chk("t1_wr", mem_wr, 1);
        chk("t1_addr", mem_addr, 32'hBFAF_F000);   chk("t1_wdata", mem_wdata, 32'h1234_5678);
        step(); chk("t1_req_t3", mem_req, 0);      chk("t1_busy_t3", wbuf_empty, 0);
        step(); chk("t1_dok_t4", mem_data_ok, 1);  chk("t1_busy_t4", wbuf_empty, 0);
        step(); chk("t1_empty_t5", wbuf_empty, 1);

        // fill the buffer with memory stalled
        dly_min = 1; dly_max = 1; hold_aok = 1; base = st_acc; pbase = pops;
        for (int i = 0; i < 5; i++) req_q.push_back(mk(1'b1, 2'd2, 32'h2000 + 4 * i, 32'h5500 + i));
        repeat (8) step();
        chk("t2_accepted", st_acc - base, 4);
        chk("t2_fifth_held", cpu_req && !cpu_addr_ok, 1);
        chk("t2_draining", mem_req, 1);
        hold_aok = 0; n = 0;
        while (st_acc - base < 5 && n < 20) begin step(); n++; end
        chk("t2_fifth_accepted", st_acc - base, 5);
        chk("t2_pop_before_fifth", pops_at_st_hs - pbase >= 1, 1);
        run_quiet("t2_drain", 100);

        // load to an unrelated address behind two stores
        mlog.delete();
        req_q.push_back(mk(1'b1, 2'd2, 32'h100, 32'hAAAA_0001));
        req_q.push_back(mk(1'b1, 2'd2, 32'h104, 32'hAAAA_0002));
        req_q.push_back(mk(1'b0, 2'd2, 32'h200, 32'h0));
        run_quiet("t3_drain", 60);
        chk("t3_count", mlog.size(), 3);
        if (mlog.size() == 3) begin
            chk("t3_first", mlog[0], 32'h100);
`ifdef DWB_READ_BYPASS_EN
            chk("t3_second", mlog[1], 32'h200); chk("t3_third", mlog[2], 32'h104);
`else
            chk("t3_second", mlog[1], 32'h104); chk("t3_third", mlog[2], 32'h200);
`endif
        end

        // load hitting a pending store must see the stored value
        mem[30'h41] = 32'h1111_1111; arch[30'h41] = 32'h1111_1111;
        req_q.push_back(mk(1'b1, 2'd2, 32'h104, 32'hCAFE_F00D));
        req_q.push_back(mk(1'b0, 2'd2, 32'h104, 32'h0));
        run_quiet("t4_drain", 60);
        chk("t4_rdata", last_ld_data, 32'hCAFE_F00D);
        chk("t4_load_after_pop", last_ld_hs_cyc > last_pop_cyc, 1);

        // store then load back to back: acks in order
        req_q.push_back(mk(1'b1, 2'd2, 32'h300, 32'h0BAD_BEEF));
        req_q.push_back(mk(1'b0, 2'd2, 32'h400, 32'h0));
        run_quiet("t5_drain", 60);
        chk("t5_ack_latency", last_st_ack_cyc - last_st_hs_cyc, 1);
        chk("t5_load_not_early", last_ld_hs_cyc >= last_st_hs_cyc + 2, 1);
        chk("t5_order", last_ld_dok_cyc > last_st_ack_cyc, 1);

        // reset while the head store waits for data_ok
        hold_aok = 1; base = st_acc; n = 0;
        for (int i = 0; i < 3; i++) req_q.push_back(mk(1'b1, 2'd2, 32'h500 + 4 * i, 32'h7700 + i));
        while (st_acc - base < 3 && n < 20) begin step(); n++; end
        hold_aok = 0; dly_min = 3; dly_max = 3; n = 0;
        while (!sl_busy && n < 20) begin step(); n++; end
        chk("t6_in_wdata", sl_busy, 1);
        @(negedge clk);
        rst = 1; cpu_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        @(negedge clk); #1;
        chk("t6_mem_req", mem_req, 0); chk("t6_data_ok", cpu_data_ok, 0);
        chk("t6_empty", wbuf_empty, 1);
        rst = 0; mem_data_ok = 1;
        #1; chk("t6_late_dok", cpu_data_ok, 0);
        @(negedge clk); mem_data_ok = 0; #1;
        chk("t6_idle_req", mem_req, 0); chk("t6_idle_empty", wbuf_empty, 1);
        pend.delete(); req_q.delete(); arch = mem;
        load_out = 0; ld_issued = 0; sl_busy = 0; ack_pend = 0; drop = 0; pv_wait = 0;

        // randomized traffic with random memory latencies
        dly_min = 1; dly_max = 3;
        for (int k = 0; k < 2000; k++) begin
            aok_pct = (k < 1000) ? 100 : 40;
            if (req_q.size() == 0 && $urandom_range(0, 2) != 0) req_q.push_back(rand_req());
            step();
        end
        run_quiet("rand_drain", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
